// File: rtl/printf_serializer_pkg.sv
// Shared printf message types and header helper for the printf serializer path.
// A header word carries id [31:16], payload word count [15:8] and sequence [7:0].
package printf_pkg;

  localparam int PRINTF_ID_WIDTH   = 16;
  localparam int PRINTF_DATA_WIDTH = 128;
  localparam int PRINTF_WORD_WIDTH = 32;
  localparam int PRINTF_NWORDS     = PRINTF_DATA_WIDTH / PRINTF_WORD_WIDTH;

  localparam int HDR_ID_LSB    = 16;
  localparam int HDR_COUNT_LSB = 8;
  localparam int HDR_SEQ_LSB   = 0;

  typedef struct packed {
    logic [PRINTF_ID_WIDTH-1:0]   id;
    logic [PRINTF_DATA_WIDTH-1:0] payload;
  } printf_msg_t;

  function automatic logic [PRINTF_WORD_WIDTH-1:0] make_header(
    input logic [PRINTF_ID_WIDTH-1:0] id,
    input logic [7:0]                 count,
    input logic [7:0]                 seq
  );
    logic [PRINTF_WORD_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[HDR_ID_LSB +: PRINTF_ID_WIDTH] = id;
    hdr[HDR_COUNT_LSB +: 8]            = count;
    hdr[HDR_SEQ_LSB +: 8]              = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/printf_serializer_if.sv
// Message-in / word-out handshake bundle of the printf serializer.
// master is the producer/consumer environment, slave is the serializer itself.
interface printf_serializer_if;
  import printf_pkg::*;

  logic                         enq_ena;
  printf_msg_t                  enq_v;
  logic                         enq_rdy;
  logic                         out_ena;
  logic [PRINTF_WORD_WIDTH-1:0] out_v;
  logic                         out_rdy;
  logic                         busy;

  modport master (
    output enq_ena, enq_v, out_rdy,
    input  enq_rdy, out_ena, out_v, busy
  );

  modport slave (
    input  enq_ena, enq_v, out_rdy,
    output enq_rdy, out_ena, out_v, busy
  );

endinterface

// File: rtl/printf_serializer.sv
// Holds one {id, payload} message and emits it as a header word followed by
// NWORDS payload words, lsb word first, accepting the next message on the last word.
module printf_serializer
  import printf_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  printf_serializer_if.slave  bus
);

  localparam logic [2:0] LAST_IDX  = 3'(PRINTF_NWORDS);
  localparam logic [7:0] HDR_COUNT = 8'(PRINTF_NWORDS);

  printf_msg_t                  msg_r;
  logic                         valid_r;
  logic [2:0]                   idx_r;
  logic [7:0]                   seq_r;

  logic                         enq_rdy_s;
  logic                         enq_take_s;
  logic                         out_take_s;
  logic                         last_take_s;
  logic [PRINTF_WORD_WIDTH-1:0] words_s [PRINTF_NWORDS];
  logic [PRINTF_WORD_WIDTH-1:0] pay_word_s;
  logic [PRINTF_WORD_WIDTH-1:0] out_word_s;

  for (genvar g = 0; g < PRINTF_NWORDS; g++) begin : g_words
    assign words_s[g] = msg_r.payload[g*PRINTF_WORD_WIDTH +: PRINTF_WORD_WIDTH];
  end

  // Handshake qualifiers; the last payload word frees the slot in the same cycle.
  always_comb begin
    out_take_s  = valid_r && bus.out_rdy;
    last_take_s = out_take_s && (idx_r == LAST_IDX);
    enq_rdy_s   = !valid_r || ((idx_r == LAST_IDX) && bus.out_rdy);
    enq_take_s  = bus.enq_ena && enq_rdy_s;
  end

  // Output word select: header at idx 0, payload word idx-1 otherwise.
  always_comb begin
    pay_word_s = '0;
    for (int k = 0; k < PRINTF_NWORDS; k++) begin
      pay_word_s = pay_word_s | ((idx_r == 3'(k + 1)) ? words_s[k] : '0);
    end
    out_word_s = (idx_r == 3'd0) ? make_header(msg_r.id, HDR_COUNT, seq_r) : pay_word_s;
  end

  // Message slot, word index and sequence counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      msg_r   <= '0;
      valid_r <= 1'b0;
      idx_r   <= 3'd0;
      seq_r   <= 8'd0;
    end else begin
      if (enq_take_s) begin
        msg_r   <= bus.enq_v;
        valid_r <= 1'b1;
        idx_r   <= 3'd0;
      end else if (last_take_s) begin
        valid_r <= 1'b0;
        idx_r   <= 3'd0;
      end else if (out_take_s) begin
        idx_r   <= idx_r + 3'd1;
      end else begin
        idx_r   <= idx_r;
      end
      if (last_take_s) begin
        seq_r <= seq_r + 8'd1;
      end else begin
        seq_r <= seq_r;
      end
    end
  end

  assign bus.enq_rdy = enq_rdy_s;
  assign bus.out_ena = valid_r;
  assign bus.out_v   = out_word_s;
  assign bus.busy    = valid_r;

endmodule

// File: tb/tb_printf_serializer.sv
// Self-checking bench for printf_serializer: directed table, hand sequences,
// and a random run checked against a queue-of-words reference model.
module tb_printf_serializer;
  import printf_pkg::*;

  logic clk;
  logic rst;
  printf_serializer_if bus ();

  printf_serializer dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words still owed to the output, oldest first.
  logic [31:0] exp_q[$];
  logic        hdr_q[$];
  logic [7:0]  m_seq;
  int          msgs_accepted;
  int          hdr_seen;
  logic        bad_id_seen;
  logic [31:0] s_out_v;
  logic        s_out_ena;

  typedef struct {
    logic         enq_ena;
    logic [15:0]  id;
    logic [127:0] pay;
    logic         out_rdy;
    logic         exp_ena;
    logic [31:0]  exp_v;
    logic         exp_rdy;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: compare DUT with model before the edge, advance model at the edge.
  task automatic cycle();
    logic exp_rdy;
    logic take_out;
    logic take_enq;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_rdy);
    chk("model_out_ena", {31'd0, bus.out_ena}, {31'd0, exp_q.size() != 0});
    chk("model_enq_rdy", {31'd0, bus.enq_rdy}, {31'd0, exp_rdy});
    chk("model_busy", {31'd0, bus.busy}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("model_out_v", bus.out_v, exp_q[0]);
    s_out_v   = bus.out_v;
    s_out_ena = bus.out_ena;
    take_out  = bus.out_rdy && (exp_q.size() != 0);
    take_enq  = bus.enq_ena && exp_rdy;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      hdr_q.delete();
      m_seq = 8'd0;
    end else begin
      if (s_out_ena && bus.out_rdy && s_out_v[31:8] == 24'h009904) bad_id_seen = 1'b1;
      if (take_out) begin
        if (hdr_q[0]) begin
          chk("hdr_seq_run", {24'd0, s_out_v[7:0]}, {24'd0, 8'(hdr_seen)});
          hdr_seen++;
        end
        void'(exp_q.pop_front());
        void'(hdr_q.pop_front());
      end
      if (take_enq) begin
        exp_q.push_back({bus.enq_v.id, 8'd4, m_seq});
        hdr_q.push_back(1'b1);
        for (int w = 0; w < 4; w++) begin
          exp_q.push_back(bus.enq_v.payload[w*32 +: 32]);
          hdr_q.push_back(1'b0);
        end
        m_seq = m_seq + 8'd1;
        msgs_accepted++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic ena, input logic [15:0] id, input logic [127:0] pay, input logic ordy);
    bus.enq_ena = ena;
    bus.enq_v   = {id, pay};
    bus.out_rdy = ordy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    hdr_seen = 0;
  endtask

  localparam logic [127:0] PA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] PB = 128'h88888888_77777777_66666666_55555555;

  initial begin
    logic [127:0] rp;
    logic [15:0]  rid;
    int           budget;
    rst = 1'b0;
    m_seq = 8'd0;
    msgs_accepted = 0;
    hdr_seen = 0;
    bad_id_seen = 1'b0;
    drive(1'b0, 16'h0000, 128'd0, 1'b1);

    tbl[0]  = '{1'b1, 16'h0012, PA, 1'b1, 1'b0, 32'h00000000, 1'b1};
    tbl[1]  = '{1'b1, 16'h0034, PB, 1'b1, 1'b1, 32'h00120400, 1'b0};
    tbl[2]  = '{1'b1, 16'h0034, PB, 1'b1, 1'b1, 32'h11111111, 1'b0};
    tbl[3]  = '{1'b1, 16'h0034, PB, 1'b1, 1'b1, 32'h22222222, 1'b0};
    tbl[4]  = '{1'b1, 16'h0034, PB, 1'b1, 1'b1, 32'h33333333, 1'b0};
    tbl[5]  = '{1'b1, 16'h0034, PB, 1'b1, 1'b1, 32'h44444444, 1'b1};
    tbl[6]  = '{1'b0, 16'h0000, 128'd0, 1'b1, 1'b1, 32'h00340401, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 128'd0, 1'b1, 1'b1, 32'h55555555, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 128'd0, 1'b1, 1'b1, 32'h66666666, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 128'd0, 1'b1, 1'b1, 32'h77777777, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 128'd0, 1'b1, 1'b1, 32'h88888888, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 128'd0, 1'b1, 1'b0, 32'h00000000, 1'b1};

    do_reset();
    #1;
    chk("reset_enq_rdy", {31'd0, bus.enq_rdy}, 32'd1);
    chk("reset_out_ena", {31'd0, bus.out_ena}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);

    // Single message then back-to-back second message.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].enq_ena, tbl[i].id, tbl[i].pay, tbl[i].out_rdy);
      #1;
      chk($sformatf("tbl%0d_ena", i), {31'd0, bus.out_ena}, {31'd0, tbl[i].exp_ena});
      chk($sformatf("tbl%0d_rdy", i), {31'd0, bus.enq_rdy}, {31'd0, tbl[i].exp_rdy});
      if (tbl[i].exp_ena) chk($sformatf("tbl%0d_v", i), bus.out_v, tbl[i].exp_v);
      cycle();
    end

    // Backpressure during PAY(1) with an illegal enq of id 0x0099.
    drive(1'b1, 16'h0056, PA, 1'b1);
    cycle();
    drive(1'b0, 16'h0000, 128'd0, 1'b1);
    cycle();
    cycle();
    drive(1'b1, 16'h0099, PB, 1'b0);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("stall_v", bus.out_v, 32'h22222222);
      chk("stall_ena", {31'd0, bus.out_ena}, 32'd1);
      chk("stall_enq_rdy", {31'd0, bus.enq_rdy}, 32'd0);
      cycle();
    end
    drive(1'b0, 16'h0000, 128'd0, 1'b1);
    #1;
    chk("resume_v1", bus.out_v, 32'h22222222);
    cycle();
    #1;
    chk("resume_v2", bus.out_v, 32'h33333333);
    for (int i = 0; i < 3; i++) cycle();

    // Reset during PAY(2).
    drive(1'b1, 16'h00ab, PB, 1'b1);
    cycle();
    drive(1'b0, 16'h0000, 128'd0, 1'b1);
    cycle();
    cycle();
    cycle();
    #1;
    chk("pre_rst_v", bus.out_v, 32'h77777777);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("post_rst_ena", {31'd0, bus.out_ena}, 32'd0);
    chk("post_rst_rdy", {31'd0, bus.enq_rdy}, 32'd1);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    hdr_seen = 0;
    drive(1'b1, 16'h00cd, PA, 1'b1);
    cycle();
    drive(1'b0, 16'h0000, 128'd0, 1'b1);
    #1;
    chk("post_rst_hdr", bus.out_v, 32'h00cd0400);
    for (int i = 0; i < 6; i++) cycle();

    // Random traffic over 257 messages to exercise the sequence wrap.
    do_reset();
    msgs_accepted = 0;
    budget = 0;
    while ((msgs_accepted < 257 || exp_q.size() != 0) && budget < 20000) begin
      rp  = {$urandom, $urandom, $urandom, $urandom};
      rid = 16'($urandom);
      if (rid == 16'h0099) rid = 16'h0098;
      drive((msgs_accepted < 257) && ($urandom_range(0, 3) != 0), rid, rp,
            $urandom_range(0, 3) != 0);
      cycle();
      budget++;
    end
    chk("random_budget", {31'd0, budget < 20000}, 32'd1);
    chk("wrap_hdr_count", 32'(hdr_seen), 32'd257);
    chk("illegal_id_absent", {31'd0, bad_id_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
